alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Sits upstream of the 16-bit ALU and drives it: accepts operation requests (opcode, A, B) over valid/ready.
//  Registers the operands and drives them onto the ALU inputs.
//  After ALU_LAT cycles, captures the ALU result and the Z/N/C/O flags, returns them over valid/ready, and keeps
//  the architectural flag register. One operation is in flight at a time.
// PARAMETERS
//  WIDTH    16  operand/result width
//  OPW      3   ALU opcode width
//  ALU_LAT  1   cycles the ALU outputs need to settle before capture; legal range 1..15
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      sequencer can accept (high only in IDLE)
//  req_opcode   in   OPW    ALU opcode
//  req_a        in   WIDTH  operand A
//  req_b        in   WIDTH  operand B
//  req_cond     in   3      condition code (only with ALU_SEQ_COND_EN)
//  alu_a        out  WIDTH  registered operand to ALU A
//  alu_b        out  WIDTH  registered operand to ALU B
//  alu_opcode   out  OPW    registered opcode to ALU
//  alu_out      in   WIDTH  ALU result
//  alu_z/alu_n/alu_c/alu_o  in  1 each  ALU flags
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer takes response
//  rsp_data     out  WIDTH  captured result
//  rsp_flags    out  4      captured {Z,N,C,O}
//  rsp_skipped  out  1      op not executed (only with ALU_SEQ_COND_EN)
//  flags        out  4      architectural flag register {Z,N,C,O}
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, except req_ready=1. FSM is in IDLE; wait counter=0.
//   Reset mid-operation aborts the op: no response is produced and the flag register is cleared.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On edge N with req_valid&&req_ready, latch req_a/req_b/req_opcode into alu_a/alu_b/alu_opcode,
//    load counter=ALU_LAT-1, go to WAIT.
//   WAIT: alu_* held stable. On the edge where counter==0, capture alu_out->rsp_data and {z,n,c,o}->rsp_flags and flags,
//    set rsp_valid, go to RESP. Otherwise decrement the counter.
//    Net effect: rsp_valid rises on edge N+ALU_LAT.
//   RESP: rsp_valid, rsp_data and rsp_flags are held until rsp_valid&&rsp_ready.
//    On that edge clear rsp_valid and go to IDLE. req_ready is first high the cycle after; there is no back-to-back bypass.
//  req_valid outside IDLE is ignored; the request source must hold its request until accepted.
//  alu_a/alu_b/alu_opcode keep their last value after the op completes; they are not cleared.
//  The flag register changes only at capture. rsp_flags of a completed op equals flags until the next capture.
//  No arithmetic is done here; widths pass through unchanged.
// CONFIGURATION
//  Macro ALU_SEQ_COND_EN enables conditional execution.
//   With the macro: the req_cond and rsp_skipped ports exist.
//    req_cond is evaluated against the flag register at acceptance:
//     000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 O, 111 never.
//    If true: normal op with rsp_skipped=0.
//    If false: alu_* are not updated and WAIT is skipped; go straight to RESP with rsp_valid on edge N+1,
//     rsp_data=0, rsp_flags=current flags, rsp_skipped=1, and the flag register unchanged.
//   Without the macro: the ports are absent and every request executes.
// STRUCTURE
//  Shared header alu_defs.vh holds:
//   - ALU opcode localparams
//   - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_O=0
//   - condition-code localparams COND_*
//   - FSM state encodings
//  One sub-module, alu_cond_eval: combinational; inputs (cond[2:0], flags[3:0]), output take. It is instantiated
//   only under ALU_SEQ_COND_EN.
//  The ALU itself is instantiated by the parent, not inside this block.
// TESTING
//  Bench ALU model: opcode 000=A+B, 001=A-B; flags derived per result.
//  1) Reset, then req opcode=000 A=10 B=10 -> rsp_valid on edge N+1, rsp_data=20, rsp_flags=0000, flags=0000.
//  2) opcode=001 A=10 B=10 -> rsp_data=0, rsp_flags Z=1. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable
//     and req_ready=0 throughout.
//  3) ALU_LAT=3 with opcode=000 A=16'hFFFF B=1 -> rsp_valid on edge N+3, rsp_data=0, Z=1 C=1.
//     Bench ALU output changed in the WAIT cycles before capture -> only the final value is captured.
//  4) Assert rst in WAIT and in RESP -> rsp_valid=0, flags=0, req_ready=1 immediately, and no response appears after
//     reset release.
//  5) ALU_SEQ_COND_EN: after the Z=1 result, send cond=010 A=1 B=1 -> rsp_skipped=1 on edge N+1, rsp_data=0,
//     flags unchanged.
//     Then send cond=001 -> op executes.
//  6) req_valid held high through WAIT/RESP with changing operands -> only the first request is accepted,
//     and the next is accepted only once back in IDLE.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcodes, flag indices, condition codes and FSM states
package alu_op_sequencer_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_N      = 3'd3;
  localparam logic [2:0] COND_NN     = 3'd4;
  localparam logic [2:0] COND_C      = 3'd5;
  localparam logic [2:0] COND_O      = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// rtl/alu_cond_eval.sv - evaluates a 3-bit condition code against the {Z,N,C,O} flag register
module alu_cond_eval
  import alu_op_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_Z:      take = flags[FLAG_Z];
      COND_NZ:     take = ~flags[FLAG_Z];
      COND_N:      take = flags[FLAG_N];
      COND_NN:     take = ~flags[FLAG_N];
      COND_C:      take = flags[FLAG_C];
      COND_O:      take = flags[FLAG_O];
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - single-op-in-flight sequencer driving an external ALU
// Optional conditional execution is enabled by defining ALU_SEQ_COND_EN.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_COND_EN
  input  logic [2:0]       req_cond,
  output logic             rsp_skipped,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] alu_flags;
  logic       take, skip_q, accept, capture;

  assign alu_flags = {alu_z, alu_n, alu_c, alu_o};
  assign accept    = (state == ST_IDLE) && req_valid;
  assign capture   = (state == ST_WAIT) && (cnt == 4'd0);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

`ifdef ALU_SEQ_COND_EN
  alu_cond_eval u_cond (
    .cond  (req_cond),
    .flags (flags),
    .take  (take)
  );
  assign rsp_skipped = skip_q;
`else
  assign take = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A skipped op passes through WAIT with a zero count so its response still lands one edge after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      skip_q     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_data   <= '0;
      rsp_flags  <= 4'd0;
      flags      <= 4'd0;
    end else begin
      if (accept) begin
        cnt    <= take ? LAT_M1 : 4'd0;
        skip_q <= ~take;
        if (take) begin
          alu_a      <= req_a;
          alu_b      <= req_b;
          alu_opcode <= req_opcode;
        end
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        if (skip_q) begin
          rsp_data  <= '0;
          rsp_flags <= flags;
        end else begin
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags;
          flags     <= alu_flags;
        end
      end
    end
  end

endmodule
